// File: rtl/hex_display_pkg.sv
// Shared constants for the hex seven-segment display controller:
// active-low glyph table, blank pattern and segment bit positions.
package hex_display_pkg;

   localparam int SEG_W = 7;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   // Element n is the g..a pattern for nibble n; listed F down to 0.
   localparam logic [15:0][SEG_W-1:0] GLYPHS = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational nibble to active-low seven-segment pattern (bit 0 = a, bit 6 = g).
module hex7seg_decoder
   import hex_display_pkg::*;
(
   input  logic [3:0]       i_nib,
   output logic [SEG_W-1:0] o_seg
);

   assign o_seg[SEG_G:SEG_A] = GLYPHS[i_nib];

endmodule

// File: rtl/hex_display_ctrl.sv
// N-digit hex seven-segment controller: registered value, leading-zero blanking,
// per-digit blink, static per-digit outputs plus a multiplexed scan output.
module hex_display_ctrl
   import hex_display_pkg::*;
#(
   parameter int DIGITS    = 4,
   parameter int BLINK_DIV = 25000000,
   parameter int SCAN_DIV  = 50000
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_load,
   input  logic [4*DIGITS-1:0]     i_value,
   input  logic                    i_blank_lz,
   input  logic [DIGITS-1:0]       i_blink_en,
   output logic [SEG_W*DIGITS-1:0] o_seg_out,
   output logic [SEG_W-1:0]        o_scan_seg,
   output logic [DIGITS-1:0]       o_scan_an
);

   localparam int BW = $clog2(BLINK_DIV);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   logic [4*DIGITS-1:0]            r_value;
   logic [BW-1:0]                  r_blink_cnt;
   logic                           r_blink_off;
   logic [SW-1:0]                  r_scan_cnt;
   logic [IW-1:0]                  r_scan_idx;
   logic [DIGITS-1:0][SEG_W-1:0]   r_seg_out;
   logic [SEG_W-1:0]               r_scan_seg;
   logic [DIGITS-1:0]              r_scan_an;

   logic [DIGITS-1:0][SEG_W-1:0]   w_glyph;
   logic [DIGITS-1:0][SEG_W-1:0]   w_final;
   logic [DIGITS-1:0]              w_lz;
   logic                           w_zero_run;

   // A load restarts the blink so freshly loaded digits are always seen first.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_value     <= '0;
         r_blink_cnt <= '0;
         r_blink_off <= 1'b0;
      end else if (i_load) begin
         r_value     <= i_value;
         r_blink_cnt <= '0;
         r_blink_off <= 1'b0;
      end else if (r_blink_cnt == BLINK_LAST) begin
         r_blink_cnt <= '0;
         r_blink_off <= ~r_blink_off;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_scan_cnt <= '0;
         r_scan_idx <= '0;
      end else if (r_scan_cnt == SCAN_LAST) begin
         r_scan_cnt <= '0;
         r_scan_idx <= (r_scan_idx == IDX_LAST) ? '0 : r_scan_idx + 1'b1;
      end else begin
         r_scan_cnt <= r_scan_cnt + 1'b1;
      end
   end

   // Walk from the top digit down; digit 0 is never part of the zero run.
   always_comb begin
      w_lz       = '0;
      w_zero_run = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         w_zero_run = w_zero_run & (r_value[4*k +: 4] == 4'h0);
         w_lz[k]    = i_blank_lz & w_zero_run;
      end
   end

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      hex7seg_decoder u_dec (
         .i_nib (r_value[4*k +: 4]),
         .o_seg (w_glyph[k])
      );
      assign w_final[k] = (w_lz[k] | (r_blink_off & i_blink_en[k])) ? SEG_BLANK : w_glyph[k];
   end

   // Anode and segments load on the same edge from the same index: no ghost cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_seg_out  <= {DIGITS{SEG_BLANK}};
         r_scan_seg <= SEG_BLANK;
         r_scan_an  <= '1;
      end else begin
         r_seg_out  <= w_final;
         r_scan_seg <= w_final[r_scan_idx];
         r_scan_an  <= ~(DIGITS'(1) << r_scan_idx);
      end
   end

   assign o_seg_out  = r_seg_out;
   assign o_scan_seg = r_scan_seg;
   assign o_scan_an  = r_scan_an;

endmodule
